// File: rtl/execute_unit.sv
// Execute stage behind the 8x16 register file: single-cycle ALU plus an optional
// iterative shift-add multiplier (built only when MUL_EXEC_EN is defined).
module execute_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  operandA,
  input  logic [WIDTH-1:0]  operandB,
  input  logic [ADDR_W-1:0] destAddr,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  result,
  output logic [ADDR_W-1:0] resultAddr,
  output logic              writeEnable,
  output logic              zeroFlag,
  output logic              carryFlag,
  output logic              illegal
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MOVB = 4'd8;

`ifdef MUL_EXEC_EN
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam int         CNT_W   = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t r_state, w_next, w_tgt;

  logic              r_run;
  logic [WIDTH-1:0]  r_result;
  logic [ADDR_W-1:0] r_addr;
  logic              r_carry;
  logic              r_illegal;

  logic              w_accept;
  logic [WIDTH-1:0]  w_res;
  logic              w_carry;
  logic              w_ill;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH:0]    w_shl;
  logic [WIDTH:0]    w_shr;
  logic [SH_W-1:0]   w_sh;

`ifdef MUL_EXEC_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_is_mul;
  assign w_is_mul = (opcode == OP_MUL);
  assign w_tgt    = w_is_mul ? S_MULT : S_DONE;
`else
  assign w_tgt    = S_DONE;
`endif

  // r_run holds inReady low until the first clock after reset release
  assign inReady     = r_run & ((r_state == S_IDLE) | ((r_state == S_DONE) & outReady));
  assign w_accept    = inValid & inReady;
  assign outValid    = (r_state == S_DONE);
  assign result      = r_result;
  assign resultAddr  = r_addr;
  assign carryFlag   = r_carry;
  assign illegal     = r_illegal;
  assign zeroFlag    = outValid & (r_result == '0);
  assign writeEnable = outValid & outReady & ~r_illegal;

  // Extra top/bottom bit captures the last bit shifted out as the carry
  assign w_sh   = operandB[SH_W-1:0];
  assign w_sum  = {1'b0, operandA} + {1'b0, operandB};
  assign w_diff = {1'b0, operandA} - {1'b0, operandB};
  assign w_shl  = {1'b0, operandA} << w_sh;
  assign w_shr  = {operandA, 1'b0} >> w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ill   = 1'b0;
    case (opcode)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      OP_AND:  w_res = operandA & operandB;
      OP_OR:   w_res = operandA | operandB;
      OP_XOR:  w_res = operandA ^ operandB;
      OP_SHL:  begin w_res = w_shl[WIDTH-1:0]; w_carry = w_shl[WIDTH]; end
      OP_SHR:  begin w_res = w_shr[WIDTH:1];   w_carry = w_shr[0];     end
      OP_MOVB: w_res = operandB;
`ifdef MUL_EXEC_EN
      OP_MUL:  w_res = '0;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_tgt;
      S_DONE: begin
        if (outReady) w_next = w_accept ? w_tgt : S_IDLE;
      end
`ifdef MUL_EXEC_EN
      S_MULT: if (r_cnt == CNT_W'(WIDTH)) w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_run     <= 1'b0;
      r_result  <= '0;
      r_addr    <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
`ifdef MUL_EXEC_EN
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
`endif
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_addr    <= destAddr;
        r_result  <= w_res;
        r_carry   <= w_carry;
        r_illegal <= w_ill;
`ifdef MUL_EXEC_EN
        if (w_is_mul) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, operandA};
          r_mplier <= operandB;
          r_cnt    <= '0;
        end
`endif
      end
`ifdef MUL_EXEC_EN
      // WIDTH add/shift iterations, then one cycle to publish the product
      else if (r_state == S_MULT) begin
        if (r_cnt == CNT_W'(WIDTH)) begin
          r_result <= r_acc[WIDTH-1:0];
          r_carry  <= |r_acc[2*WIDTH-1:WIDTH];
        end else begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: expected results are queued at accept time
// and compared when the output handshake completes.
module tb_execute_unit;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          inValid = 1'b0;
  logic          outReady = 1'b0;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  operandA = '0;
  logic [W-1:0]  operandB = '0;
  logic [AW-1:0] destAddr = '0;
  logic          inReady, outValid, writeEnable, zeroFlag, carryFlag, illegal;
  logic [W-1:0]  result;
  logic [AW-1:0] resultAddr;

  execute_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .opcode(opcode), .operandA(operandA), .operandB(operandB), .destAddr(destAddr),
    .outValid(outValid), .outReady(outReady), .result(result), .resultAddr(resultAddr),
    .writeEnable(writeEnable), .zeroFlag(zeroFlag), .carryFlag(carryFlag), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [AW-1:0] addr;
    logic          zero;
    logic          carry;
    logic          ill;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    logic [W:0] s;
    int sh;
`ifdef MUL_EXEC_EN
    logic [2*W-1:0] p;
`endif
    e.res = '0; e.carry = 1'b0; e.ill = 1'b0; e.addr = d;
    sh = int'(b[3:0]);
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.carry = s[W]; end
      4'd1: begin e.res = a - b; e.carry = (a < b); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: begin e.res = a << sh; e.carry = (sh == 0) ? 1'b0 : a[W-sh]; end
      4'd6: begin e.res = a >> sh; e.carry = (sh == 0) ? 1'b0 : a[sh-1]; end
`ifdef MUL_EXEC_EN
      4'd7: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0]; e.carry = (p[2*W-1:W] != '0);
      end
`endif
      4'd8: e.res = b;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Sample just after inputs settle, then advance to 1ns past the next edge
  task automatic tick(output bit acc);
    exp_t e;
    #2;
    acc = inValid && inReady;
    if (outValid && outReady) begin
      if (sbq.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("addr", resultAddr, e.addr);
        chk("zero", zeroFlag, e.zero);
        chk("carry", carryFlag, e.carry);
        chk("illegal", illegal, e.ill);
        chk("wen", writeEnable, !e.ill);
      end
    end
    if (acc) sbq.push_back(model(opcode, operandA, operandB, destAddr));
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [AW-1:0] d);
    bit acc;
    int n;
    opcode = op; operandA = a; operandB = b; destAddr = d; inValid = 1'b1;
    n = 0;
    do begin tick(acc); n++; end while (!acc && n < 60);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    inValid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    outReady = 1'b1;
    n = 0;
    while (sbq.size() > 0 && n < 100) begin tick(acc); n++; end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    logic [W-1:0] hold;

    // reset state
    @(posedge clock); #1;
    chk("rst_valid", outValid, 0);
    chk("rst_ready", inReady, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zeroFlag, 0);
    chk("rst_carry", carryFlag, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_wen", writeEnable, 0);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    #2 chk("rdy_pre_clk", inReady, 0);
    @(posedge clock); #1;
    chk("rdy_post_clk", inReady, 1);

    // ADD wrap: zero and carry
    outReady = 1'b1;
    send(4'd0, 16'hFFFF, 16'h0001, 3'd3);
    chk("t1_lat", outValid, 1);
    chk("t1_res", result, 16'h0000);
    chk("t1_zero", zeroFlag, 1);
    chk("t1_carry", carryFlag, 1);
    chk("t1_addr", resultAddr, 3);
    chk("t1_wen", writeEnable, 1);
    drain();

    // SUB/shift/logic mix back to back
    send(4'd1, 16'h0005, 16'h0007, 3'd1);
    send(4'd5, 16'h8001, 16'h0001, 3'd2);
    send(4'd6, 16'h0003, 16'h0001, 3'd4);
    send(4'd5, 16'h1234, 16'h0000, 3'd5);
    send(4'd6, 16'h8000, 16'h000F, 3'd6);
    send(4'd2, 16'hF0F0, 16'h3C3C, 3'd7);
    send(4'd3, 16'hF0F0, 16'h0F0F, 3'd0);
    send(4'd4, 16'hAAAA, 16'hAAAA, 3'd1);
    send(4'd8, 16'h1111, 16'hBEEF, 3'd2);
    drain();

`ifdef MUL_EXEC_EN
    // MUL latency and busy
    send(4'd7, 16'h0100, 16'h0100, 3'd3);
    n = 0;
    while (!outValid && n < 40) begin chk("mul_busy", inReady, 0); tick(acc); n++; end
    chk("mul_lat", n, 17);
    chk("mul_res", result, 16'h0000);
    chk("mul_carry", carryFlag, 1);
    drain();
    send(4'd7, 16'h0012, 16'h0034, 3'd4);
    n = 0;
    while (!outValid && n < 40) begin tick(acc); n++; end
    chk("mul2_res", result, 16'h03A8);
    chk("mul2_carry", carryFlag, 0);
    drain();
`else
    send(4'd7, 16'h0012, 16'h0034, 3'd4);
    chk("mul_off_lat", outValid, 1);
    chk("mul_off_ill", illegal, 1);
    drain();
`endif

    // backpressure: outputs held, no write, then transfer with same-cycle accept
    outReady = 1'b0;
    send(4'd0, 16'h0001, 16'h0002, 3'd5);
    hold = result;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", outValid, 1);
      chk("bp_res", result, sbq[0].res);
      chk("bp_hold", result, hold);
      chk("bp_ready", inReady, 0);
      chk("bp_wen", writeEnable, 0);
      tick(acc);
    end
    outReady = 1'b1;
    send(4'd4, 16'h00FF, 16'h0F0F, 3'd6);
    chk("bp_b2b_valid", outValid, 1);
    drain();

    // 4-op stream, one result per cycle
    for (int i = 0; i < 4; i++) begin
      opcode = 4'd0; operandA = 16'(i * 16'h1111); operandB = 16'(i + 1);
      destAddr = 3'(i); inValid = 1'b1;
      if (i > 0) chk("stream_valid", outValid, 1);
      tick(acc);
      chk("stream_acc", acc, 1);
    end
    inValid = 1'b0;
    chk("stream_last_valid", outValid, 1);
    drain();

    // async reset with an op in flight
`ifdef MUL_EXEC_EN
    send(4'd7, 16'h0012, 16'h0034, 3'd1);
    repeat (8) tick(acc);
`else
    outReady = 1'b0;
    send(4'd0, 16'h0003, 16'h0004, 3'd1);
`endif
    resetN = 1'b0;
    #1;
    chk("rst2_valid", outValid, 0);
    chk("rst2_ready", inReady, 0);
    chk("rst2_wen", writeEnable, 0);
    sbq.delete();
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    chk("rst2_rdy", inReady, 1);
    outReady = 1'b1;
    send(4'd12, 16'h1234, 16'h5678, 3'd2);
    chk("ill_flag", illegal, 1);
    chk("ill_zero", zeroFlag, 1);
    chk("ill_wen", writeEnable, 0);
    drain();
    send(4'd15, 16'hFFFF, 16'hFFFF, 3'd7);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
